region_dispatcher: RTL and testbench

- Sits directly downstream of the load balancer: consumes its meta_out stream and lb_ctrl region selection.
- Steers each request descriptor to the selected PR region over per-region valid/ready lanes.
- Tracks per-region outstanding requests and the last dispatched operator id. Produces the packed region_stats vector the load balancer consumes.

---
 rtl/lb_pkg.sv | 25 ++
 rtl/region_credit.sv | 63 ++++++
 rtl/region_dispatcher.sv | 102 ++++++++++
 tb/tb_region_dispatcher.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// lb_pkg: types and constants shared by the load balancer and dispatcher.
// Rev 1.0
// ------------------------------------------------------------------
package lb_pkg;

  localparam int OID_WIDTH_DEF = 16;
  localparam int QDEPTH_DEF    = 16;
  localparam int LOAD_BITS     = $clog2(QDEPTH_DEF);
  localparam int OID_LSB       = 0;

  typedef struct packed {
    logic [OID_WIDTH_DEF-1:0] oid;
    logic [LOAD_BITS-1:0]     load;
  } region_stat_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DISPATCH    = 2'd1,
    ST_WAIT_CREDIT = 2'd2
  } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/region_credit.sv
`default_nettype none
// ------------------------------------------------------------------
// region_credit: per-region outstanding counter, last oid and load stats.
// Rev 1.0
// ------------------------------------------------------------------
module region_credit
  import lb_pkg::*;
#(
  parameter int OPERATOR_ID_WIDTH = 16,
  parameter int QDEPTH            = 16,
  parameter int LOAD_W            = $clog2(QDEPTH)
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                dispatch,
  input  logic [OPERATOR_ID_WIDTH-1:0]        oid,
  input  logic                                done,
  output logic                                full,
  output logic                                full_next,
  output logic                                underflow,
  output logic [OPERATOR_ID_WIDTH+LOAD_W-1:0] stats
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);
  localparam int LOAD_MAX = (1 << LOAD_W) - 1;

  logic [CW-1:0]                count, count_next;
  logic [OPERATOR_ID_WIDTH-1:0] last_oid;
  logic [LOAD_W-1:0]            load;
  logic                         inc, dec;

  always_comb begin
    count_next = count;
    inc        = dispatch && (count != DEPTH);
    dec        = done && (count != '0);
    underflow  = done && (count == '0);
    case ({inc, dec})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  assign full      = (count == DEPTH);
  assign full_next = (count_next == DEPTH);
  // The load field is narrower than the counter, so a full region reads as max load.
  assign load      = (int'(count) > LOAD_MAX) ? {LOAD_W{1'b1}} : count[LOAD_W-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count    <= '0;
      last_oid <= '0;
      stats    <= '0;
    end else begin
      count <= count_next;
      if (dispatch) last_oid <= oid;
      stats <= {last_oid, load};
    end
  end

endmodule
`default_nettype wire

// File: rtl/region_dispatcher.sv
`default_nettype none
// ------------------------------------------------------------------
// region_dispatcher: steers load-balancer descriptors to PR regions.
// Rev 1.0
// ------------------------------------------------------------------
module region_dispatcher
  import lb_pkg::*;
#(
  parameter  int HTTP_META_WIDTH   = 98,
  parameter  int OPERATOR_ID_WIDTH = 16,
  parameter  int QDEPTH            = 16,
  parameter  int N_REGIONS         = 4,
  localparam int LOAD_BITS         = $clog2(QDEPTH),
  localparam int TGT_W             = $clog2(N_REGIONS)
) (
  input  logic                                             aclk,
  input  logic                                             aresetn,
  input  logic                                             meta_in_tvalid,
  output logic                                             meta_in_tready,
  input  logic [HTTP_META_WIDTH-1:0]                       meta_in_tdata,
  input  logic [TGT_W-1:0]                                 lb_ctrl,
  output logic [N_REGIONS-1:0]                             region_tvalid,
  input  logic [N_REGIONS-1:0]                             region_tready,
  output logic [HTTP_META_WIDTH-1:0]                       region_tdata,
  input  logic [N_REGIONS-1:0]                             region_done,
  output logic [N_REGIONS*(OPERATOR_ID_WIDTH+LOAD_BITS)-1:0] region_stats_out,
  output logic                                             err
);

  localparam int SW = OPERATOR_ID_WIDTH + LOAD_BITS;
  localparam logic [TGT_W:0] N_REG_LIM = N_REGIONS[TGT_W:0];

  disp_state_t                state, state_next;
  logic [TGT_W-1:0]           tgt, tgt_sel;
  logic [HTTP_META_WIDTH-1:0] data;
  logic                       accept, handshake, bad_ctrl;
  logic [N_REGIONS-1:0]       full, full_next, underflow, dispatch_vec;

  assign bad_ctrl       = ({1'b0, lb_ctrl} >= N_REG_LIM);
  assign tgt_sel        = bad_ctrl ? '0 : lb_ctrl;
  assign handshake      = (state == ST_DISPATCH) && region_tready[tgt];
  assign meta_in_tready = (state == ST_IDLE) || handshake;
  assign accept         = meta_in_tvalid && meta_in_tready;
  assign dispatch_vec   = handshake ? ({{(N_REGIONS-1){1'b0}}, 1'b1} << tgt) : '0;
  assign region_tdata   = data;

  // Credit is judged on the post-edge count so a back-to-back dispatch is seen.
  always_comb begin
    state_next    = state;
    region_tvalid = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = full_next[tgt_sel] ? ST_WAIT_CREDIT : ST_DISPATCH;
      end
      ST_DISPATCH: begin
        region_tvalid[tgt] = 1'b1;
        if (accept)         state_next = full_next[tgt_sel] ? ST_WAIT_CREDIT : ST_DISPATCH;
        else if (handshake) state_next = ST_IDLE;
      end
      ST_WAIT_CREDIT: begin
        if (!full[tgt]) state_next = ST_DISPATCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      tgt   <= '0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        tgt  <= tgt_sel;
        data <= meta_in_tdata;
      end
      err <= err | (accept && bad_ctrl) | (|underflow);
    end
  end

  for (genvar i = 0; i < N_REGIONS; i++) begin : g_region
    region_credit #(
      .OPERATOR_ID_WIDTH (OPERATOR_ID_WIDTH),
      .QDEPTH            (QDEPTH),
      .LOAD_W            (LOAD_BITS)
    ) u_credit (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .dispatch  (dispatch_vec[i]),
      .oid       (data[OID_LSB +: OPERATOR_ID_WIDTH]),
      .done      (region_done[i]),
      .full      (full[i]),
      .full_next (full_next[i]),
      .underflow (underflow[i]),
      .stats     (region_stats_out[i*SW +: SW])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_region_dispatcher.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_region_dispatcher: self-checking bench for region_dispatcher.
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_region_dispatcher;
  import lb_pkg::*;

  localparam int W  = 98;
  localparam int OW = 16;
  localparam int QD = 16;
  localparam int NR = 4;
  localparam int LB = 4;
  localparam int SW = OW + LB;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              meta_in_tvalid = 1'b0;
  logic              meta_in_tready;
  logic [W-1:0]      meta_in_tdata = '0;
  logic [1:0]        lb_ctrl = '0;
  logic [NR-1:0]     region_tvalid;
  logic [NR-1:0]     region_tready = '0;
  logic [W-1:0]      region_tdata;
  logic [NR-1:0]     region_done = '0;
  logic [NR*SW-1:0]  region_stats_out;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  region_dispatcher #(
    .HTTP_META_WIDTH   (W),
    .OPERATOR_ID_WIDTH (OW),
    .QDEPTH            (QD),
    .N_REGIONS         (NR)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .meta_in_tvalid   (meta_in_tvalid),
    .meta_in_tready   (meta_in_tready),
    .meta_in_tdata    (meta_in_tdata),
    .lb_ctrl          (lb_ctrl),
    .region_tvalid    (region_tvalid),
    .region_tready    (region_tready),
    .region_tdata     (region_tdata),
    .region_done      (region_done),
    .region_stats_out (region_stats_out),
    .err              (err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [W-1:0] mkdesc(input logic [OW-1:0] oid);
    logic [W-1:0] d;
    d[31:0]  = $urandom;
    d[63:32] = $urandom;
    d[95:64] = $urandom;
    d[97:96] = 2'($urandom);
    d[OW-1:0] = oid;
    return d;
  endfunction

  function automatic logic [SW-1:0] mkstat(input logic [OW-1:0] oid, input int cnt);
    region_stat_t s;
    s.oid  = oid;
    s.load = (cnt > 15) ? 4'hF : 4'(cnt);
    return s;
  endfunction

  function automatic logic [SW-1:0] get_slice(input int i);
    return region_stats_out[i*SW +: SW];
  endfunction

  task automatic do_reset;
    aresetn = 1'b0;
    meta_in_tvalid = 1'b0;
    region_tready = '0;
    region_done = '0;
    lb_ctrl = '0;
    meta_in_tdata = '0;
    repeat (2) tick;
    aresetn = 1'b1;
    tick;
  endtask

  // Offers one descriptor and returns at the cycle after it was accepted.
  task automatic send_one(input logic [1:0] t, input logic [OW-1:0] oid, output logic [W-1:0] d);
    int n;
    d = mkdesc(oid);
    meta_in_tdata = d;
    lb_ctrl = t;
    meta_in_tvalid = 1'b1;
    n = 0;
    #1;
    while (!meta_in_tready && n < 50) begin
      @(posedge aclk);
      #2;
      n++;
    end
    check("send_accept", meta_in_tready, 1'b1);
    @(posedge aclk);
    #1;
    meta_in_tvalid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]    ctrl;
    logic [OW-1:0] oid;
    logic [NR-1:0] exp_valid;
    int            exp_load;
  } vec_t;

  typedef struct {
    logic [1:0]   tgt;
    logic [W-1:0] data;
  } pend_t;

  int            mcount[NR];
  logic [OW-1:0] mlast[NR];
  int            scount[NR];
  logic [OW-1:0] slast[NR];
  bit            merr;
  pend_t         q[$];

  initial begin
    vec_t         tbl[6];
    logic [W-1:0] d, d17;
    int           accepts, cycles, n;
    bit           seen;

    tbl[0] = '{2'd2, 16'h0042, 4'b0100, 1};
    tbl[1] = '{2'd0, 16'h1111, 4'b0001, 1};
    tbl[2] = '{2'd3, 16'hBEEF, 4'b1000, 1};
    tbl[3] = '{2'd2, 16'h0007, 4'b0100, 2};
    tbl[4] = '{2'd1, 16'hABCD, 4'b0010, 1};
    tbl[5] = '{2'd3, 16'h5A5A, 4'b1000, 2};

    #1;
    check("reset_tvalid", region_tvalid, '0);
    check("reset_tdata", region_tdata, '0);
    check("reset_stats", region_stats_out, '0);
    check("reset_err", err, 1'b0);
    do_reset;

    // Single-descriptor vectors, counts accumulate across entries.
    for (int k = 0; k < 6; k++) begin
      send_one(tbl[k].ctrl, tbl[k].oid, d);
      check("vec_tvalid", region_tvalid, tbl[k].exp_valid);
      check("vec_tdata", region_tdata, d);
      region_tready = tbl[k].exp_valid;
      tick;
      region_tready = '0;
      check("vec_idle_after", region_tvalid, '0);
      tick;
      check("vec_stats", get_slice(int'(tbl[k].ctrl)), mkstat(tbl[k].oid, tbl[k].exp_load));
    end
    check("vec_err", err, 1'b0);

    // Credit exhaustion on region 1.
    do_reset;
    region_tready = 4'b0010;
    lb_ctrl = 2'd1;
    meta_in_tvalid = 1'b1;
    accepts = 0;
    cycles = 0;
    d17 = '0;
    while (accepts < 17 && cycles < 40) begin
      meta_in_tdata = mkdesc(16'h0100 + 16'(accepts));
      #1;
      if (meta_in_tready) begin
        accepts++;
        if (accepts == 17) d17 = meta_in_tdata;
      end
      @(posedge aclk);
      #1;
      cycles++;
    end
    meta_in_tvalid = 1'b0;
    check("b2b_accepts", accepts, 17);
    check("b2b_cycles", cycles, 17);
    for (int k = 0; k < 3; k++) begin
      check("stall_tvalid", region_tvalid, '0);
      check("stall_tready", meta_in_tready, 1'b0);
      tick;
    end
    check("full_stats", get_slice(1), mkstat(16'h010F, 16));
    region_done = 4'b0010;
    tick;
    region_done = '0;
    seen = 0;
    n = 0;
    while (!seen && n < 5) begin
      if (region_tvalid == 4'b0010) seen = 1;
      else begin tick; n++; end
    end
    check("release_tvalid", region_tvalid, 4'b0010);
    check("release_tdata", region_tdata, d17);
    tick;
    check("release_done", region_tvalid, '0);
    tick;
    check("release_stats", get_slice(1), mkstat(16'h0110, 16));
    send_one(2'd1, 16'h0111, d);
    for (int k = 0; k < 3; k++) begin
      check("refill_stall", region_tvalid, '0);
      tick;
    end

    // Reset while stalled in WAIT_CREDIT with region 1 full.
    aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid", region_tvalid, '0);
    check("rst_mid_tdata", region_tdata, '0);
    check("rst_mid_stats", region_stats_out, '0);
    check("rst_mid_err", err, 1'b0);
    tick;
    aresetn = 1'b1;
    region_tready = '1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (region_tvalid != '0) seen = 1;
    end
    check("rst_no_tvalid", seen, 1'b0);

    // Dispatch and completion on region 3 in the same cycle.
    do_reset;
    region_tready = 4'b1000;
    for (int k = 0; k < 5; k++) send_one(2'd3, 16'h0500 + 16'(k), d);
    tick;
    tick;
    check("sim_pre_stats", get_slice(3), mkstat(16'h0504, 5));
    region_tready = '0;
    send_one(2'd3, 16'h0600, d);
    region_tready = 4'b1000;
    region_done = 4'b1000;
    tick;
    region_tready = '0;
    region_done = '0;
    tick;
    tick;
    check("sim_stats", get_slice(3), mkstat(16'h0600, 5));
    check("sim_err", err, 1'b0);

    // Completion on an idle region.
    do_reset;
    region_done = 4'b0001;
    tick;
    region_done = '0;
    tick;
    check("underflow_err", err, 1'b1);
    check("underflow_stats", get_slice(0), '0);
    region_tready = 4'b0001;
    send_one(2'd0, 16'h0777, d);
    repeat (3) tick;
    check("underflow_after", get_slice(0), mkstat(16'h0777, 1));
    check("err_sticky", err, 1'b1);

    // Backpressure from region 2.
    do_reset;
    send_one(2'd2, 16'h0222, d);
    for (int k = 0; k < 10; k++) begin
      check("bp_tvalid", region_tvalid, 4'b0100);
      check("bp_tdata", region_tdata, d);
      check("bp_meta_tready", meta_in_tready, 1'b0);
      tick;
    end
    region_tready = 4'b0100;
    #1;
    check("bp_hs_tready", meta_in_tready, 1'b1);
    tick;
    region_tready = '0;
    check("bp_done", region_tvalid, '0);
    tick;
    tick;
    check("bp_stats", get_slice(2), mkstat(16'h0222, 1));

    // Randomized traffic against a transaction-level model.
    begin
      logic [NR*SW-1:0] ev;
      bit               acc, acc_prev;
      int               stall;
      int               t;
      do_reset;
      for (int i = 0; i < NR; i++) begin
        mcount[i] = 0; mlast[i] = '0; scount[i] = 0; slast[i] = '0;
      end
      merr = 0;
      q.delete();
      acc_prev = 0;
      stall = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        for (int i = 0; i < NR; i++) ev[i*SW +: SW] = mkstat(slast[i], scount[i]);
        check("rnd_stats", region_stats_out, ev);
        check("rnd_err", err, merr);
        for (int i = 0; i < NR; i++) begin
          scount[i] = mcount[i];
          slast[i]  = mlast[i];
        end

        if (!(meta_in_tvalid && !acc_prev)) begin
          meta_in_tvalid = ($urandom_range(0, 3) != 0);
          lb_ctrl = 2'($urandom);
          meta_in_tdata = mkdesc(16'($urandom));
        end
        region_tready = 4'($urandom) | 4'($urandom);
        for (int i = 0; i < NR; i++)
          region_done[i] = ((cyc / 400) % 2 == 1) ? ($urandom_range(0, 2) == 0)
                                                  : ($urandom_range(0, 9) == 0);
        #1;

        if (q.size() == 0) check("rnd_tready_idle", meta_in_tready, 1'b1);
        else if (!region_tready[q[0].tgt]) check("rnd_tready_busy", meta_in_tready, 1'b0);
        if (region_tvalid != '0) begin
          check("rnd_tvalid_tgt", region_tvalid, (q.size() > 0) ? (4'b0001 << q[0].tgt) : 4'b0000);
          if (q.size() > 0) check("rnd_tdata", region_tdata, q[0].data);
        end
        if (q.size() > 0 && region_tvalid == '0 && mcount[q[0].tgt] < QD) stall++;
        else stall = 0;
        if (stall > 2) begin
          check("rnd_stall", stall, 0);
          stall = 0;
        end

        if (q.size() > 0 && (region_tvalid & region_tready) != '0) begin
          t = int'(q[0].tgt);
          check("rnd_credit", mcount[t] < QD, 1'b1);
          mlast[t] = q[0].data[OW-1:0];
          q.pop_front();
          for (int i = 0; i < NR; i++)
            if (region_done[i]) begin
              if (mcount[i] == 0) merr = 1;
              else mcount[i]--;
            end
          if (mcount[t] < QD) mcount[t]++;
        end else begin
          for (int i = 0; i < NR; i++)
            if (region_done[i]) begin
              if (mcount[i] == 0) merr = 1;
              else mcount[i]--;
            end
        end

        acc = meta_in_tvalid && meta_in_tready;
        if (acc) begin
          q.push_back('{lb_ctrl, meta_in_tdata});
          check("rnd_pending", q.size() <= 1, 1'b1);
        end
        acc_prev = acc;
        @(posedge aclk);
        #1;
      end
      meta_in_tvalid = 1'b0;
      region_done = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
